// File: rtl/softmax_pkg.sv
// Shared constants, flag type and exp2 fraction table generator for the softmax exp datapath.
package softmax_pkg;

  localparam int unsigned LOG2E        = 94548;  // log2(e) in Q2.16
  localparam int unsigned LOG2E_FRAC   = 16;
  localparam int unsigned LUT_BITS_DEF = 6;

  typedef struct packed {
    logic ovf;
    logic unf;
  } exp_flags_t;

  // L[i] = round(2^(i/2^lut_bits) * 2^yf); the end point is exactly 2^(yf+1).
  // Evaluated only at elaboration; the integer conversion limits yf to about 29.
  function automatic logic [63:0] exp2_lut_entry(input int unsigned i,
                                                 input int unsigned lut_bits,
                                                 input int unsigned yf);
    real v;
    real term;
    real e;
    real scale;
    logic [63:0] res;
    if (i >= (32'd1 << lut_bits)) begin
      res = 64'd1 << (yf + 1);
    end else begin
      v     = ($itor(i) / $itor(32'd1 << lut_bits)) * 0.6931471805599453;
      e     = 1.0;
      term  = 1.0;
      for (int n = 1; n < 24; n++) begin
        term = term * v / $itor(n);
        e    = e + term;
      end
      scale = 1.0;
      for (int n = 0; n < int'(yf); n++) scale = scale * 2.0;
      res = 64'($rtoi(e * scale + 0.5));
    end
    return res;
  endfunction

endpackage

// File: rtl/exp2_frac_lut.sv
// Registered dual-read ROM of 2^(i/2^LUT_BITS) values; returns adjacent entries for interpolation.
module exp2_frac_lut import softmax_pkg::*; #(
  parameter int unsigned LUT_BITS = LUT_BITS_DEF,
  parameter int unsigned YF       = 23,
  localparam int unsigned LW      = YF + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [LUT_BITS-1:0] idx,
  output logic [LW-1:0]       lo,
  output logic [LW-1:0]       hi
);

  localparam int unsigned N = 1 << LUT_BITS;

  logic [LW-1:0]     rom [N+1];
  logic [LUT_BITS:0] idx_lo;
  logic [LUT_BITS:0] idx_hi;

  for (genvar g = 0; g <= N; g++) begin : g_rom
    localparam logic [63:0] E = exp2_lut_entry(g, LUT_BITS, YF);
    assign rom[g] = LW'(E);
  end

  assign idx_lo = {1'b0, idx};
  assign idx_hi = idx_lo + (LUT_BITS + 1)'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      lo <= '0;
      hi <= '0;
    end else if (en) begin
      lo <= rom[idx_lo];
      hi <= rom[idx_hi];
    end
  end

endmodule

// File: rtl/softmax_exp_stream.sv
// Streaming fixed-point exp(x) with a 4-stage stallable pipeline, range flags and a
// per-vector saturating sum of results for the softmax denominator.
module softmax_exp_stream import softmax_pkg::*; #(
  parameter int unsigned XW       = 16,
  parameter int unsigned YW       = 46,
  parameter int unsigned YF       = 23,
  parameter int unsigned LUT_BITS = LUT_BITS_DEF,
  parameter int unsigned SW       = YW + 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [XW-1:0] x,
  input  logic [4:0]           x_shift,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [YW-1:0]        y,
  output logic                 y_ovf,
  output logic                 y_unf,
  output logic                 out_last,
  output logic                 sum_valid,
  output logic [SW-1:0]        sum
);

  localparam int unsigned TW     = XW + 18;
  localparam int unsigned KW     = XW + 2;
  localparam int unsigned FB_MAX = XW + 15;
  localparam int unsigned RW     = 24 - LUT_BITS;
  localparam int unsigned LW     = YF + 2;
  localparam int unsigned PW     = LW + RW;

  logic en;

  logic                 v1_q, v2_q, v3_q;
  logic                 l1_q, l2_q, l3_q;
  logic signed [TW-1:0] t1_q;
  logic [4:0]           sh1_q;
  logic signed [KW-1:0] k2_q, k3_q;
  logic [RW-1:0]        r2_q;
  logic [LW-1:0]        m3_q;
  logic [LW-1:0]        lut_lo, lut_hi;

  logic [4:0]           sh_c;
  logic signed [TW-1:0] t_d;
  logic [5:0]           fb;
  logic signed [KW-1:0] k_d;
  logic [FB_MAX-1:0]    frac;
  logic [FB_MAX-1:0]    frac_al;
  logic [23:0]          f24;
  logic [LUT_BITS-1:0]  idx_d;
  logic [RW-1:0]        r_d;
  logic [PW-1:0]        prod;
  logic [LW-1:0]        m_d;
  int                   k_int;
  logic [YW-1:0]        y_d;
  exp_flags_t           flags_d;

  logic [SW-1:0]        acc_q;
  logic [SW:0]          acc_add;
  logic [SW-1:0]        acc_sat;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // S1: t = x * log2(e), carrying x_shift+16 fraction bits
  always_comb begin
    sh_c = (x_shift > 5'(XW - 1)) ? 5'(XW - 1) : x_shift;
    t_d  = TW'(x) * $signed(TW'(LOG2E));
  end

  // S2: split t into integer k and a fraction aligned to 24 bits
  always_comb begin
    fb      = 6'(sh1_q) + 6'(LOG2E_FRAC);
    k_d     = KW'(t1_q >>> fb);
    // A full-width mask wraps to all ones when fb == FB_MAX, which is the intended result.
    frac    = FB_MAX'(t1_q) & ((FB_MAX'(1) << fb) - FB_MAX'(1));
    frac_al = frac << (6'(FB_MAX) - fb);
    f24     = 24'(frac_al >> (FB_MAX - 24));
    idx_d   = f24[23 -: LUT_BITS];
    r_d     = f24[RW-1:0];
  end

  exp2_frac_lut #(
    .LUT_BITS(LUT_BITS),
    .YF      (YF)
  ) u_lut (
    .clk(clk),
    .rst(rst),
    .en (en),
    .idx(idx_d),
    .lo (lut_lo),
    .hi (lut_hi)
  );

  // S3: linear interpolation between adjacent table entries, truncated
  always_comb begin
    prod = PW'(lut_hi - lut_lo) * PW'(r2_q);
    m_d  = lut_lo + LW'(prod >> RW);
  end

  // S4: scale by 2^k with saturation and flush-to-zero
  always_comb begin
    k_int   = int'(k3_q);
    y_d     = '0;
    flags_d = '0;
    if (k_int >= int'(YW - YF)) begin
      y_d         = '1;
      flags_d.ovf = 1'b1;
    end else if (k_int < -int'(YF + 1)) begin
      flags_d.unf = 1'b1;
    end else if (k_int >= 0) begin
      y_d = YW'(m3_q) << k_int;
    end else begin
      y_d         = YW'(m3_q) >> (-k_int);
      flags_d.unf = (y_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_valid <= 1'b0;
      l1_q      <= 1'b0;
      l2_q      <= 1'b0;
      l3_q      <= 1'b0;
      t1_q      <= '0;
      sh1_q     <= '0;
      k2_q      <= '0;
      r2_q      <= '0;
      k3_q      <= '0;
      m3_q      <= '0;
      y         <= '0;
      y_ovf     <= 1'b0;
      y_unf     <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      out_valid <= v3_q;
      if (in_valid) begin
        t1_q  <= t_d;
        sh1_q <= sh_c;
        l1_q  <= in_last;
      end
      if (v1_q) begin
        k2_q <= k_d;
        r2_q <= r_d;
        l2_q <= l1_q;
      end
      if (v2_q) begin
        m3_q <= m_d;
        k3_q <= k2_q;
        l3_q <= l2_q;
      end
      if (v3_q) begin
        y        <= y_d;
        y_ovf    <= flags_d.ovf;
        y_unf    <= flags_d.unf;
        out_last <= l3_q;
      end
    end
  end

  always_comb begin
    acc_add = {1'b0, acc_q} + (SW + 1)'(y);
    acc_sat = acc_add[SW] ? '1 : acc_add[SW-1:0];
  end

  // The last beat closes the vector: publish the total and restart from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (out_valid && out_ready) begin
        if (out_last) begin
          sum       <= acc_sat;
          sum_valid <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q <= acc_sat;
        end
      end
    end
  end

endmodule
